// File: rtl/mc_alu_control.sv
// Multicycle MIPS-style control FSM: drives ALU op, mux selects and PC/IR/memory/register enables.
// Latency: one state per clock; R-type 4, lw 5, sw 4, beq 3, j 3, addi 4 cycles with zero-wait memory.
// Backpressure: FETCH/MEMRD/MEMWR hold until mem_ack, abandoning to FETCH after MEM_WAIT_MAX idle cycles.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   opcode, funct      instruction fields, sampled in DECODE
//   zero               ALU zero flag, gates the branch PC load
//   mem_ack            memory completes the current access this cycle
//   alu_op .. mem_to_reg  datapath controls, decoded from state (and mem_ack/zero)
//   illegal            one-cycle pulse in DECODE on an unsupported opcode/funct
//   mem_timeout        one-cycle pulse when a memory wait expires
//   state              current state encoding, for debug
module mc_alu_control #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ack,
  output logic [3:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_source,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal,
  output logic       mem_timeout,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,  DECODE  = 4'd1,  MEMADR  = 4'd2,  MEMRD   = 4'd3,
    MEMWB   = 4'd4,  MEMWR   = 4'd5,  EXEC    = 4'd6,  RWB     = 4'd7,
    BRANCH  = 4'd8,  JUMP    = 4'd9,  ADDI_EX = 4'd10, ADDI_WB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam int CW = $clog2(MEM_WAIT_MAX + 1);

  state_t          cur;
  logic            is_sw;      // op class latched in DECODE: selects MEMWR vs MEMRD
  logic [3:0]      rtype_op;   // ALU code from funct, latched in DECODE for EXEC
  logic [CW-1:0]   wait_cnt;
  logic [3:0]      funct_op;
  logic            funct_ok;
  logic            decode_ok;
  logic            waiting;
  logic            expire;

  always_comb begin
    funct_op = 4'b0010;
    funct_ok = 1'b1;
    case (funct)
      6'b100000: funct_op = 4'b0010;
      6'b100010: funct_op = 4'b0110;
      6'b100100: funct_op = 4'b0000;
      6'b100101: funct_op = 4'b0001;
      6'b101010: funct_op = 4'b0111;
      6'b100111: funct_op = 4'b1100;
      default:   funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: decode_ok = 1'b1;
      OP_RTYPE:                            decode_ok = funct_ok;
      default:                             decode_ok = 1'b0;
    endcase
  end

  assign waiting = (cur == FETCH) || (cur == MEMRD) || (cur == MEMWR);
  // Expires on the MEM_WAIT_MAX-th consecutive un-acked cycle; an ack in that cycle wins.
  assign expire  = waiting && !mem_ack && (wait_cnt == CW'(MEM_WAIT_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= FETCH;
      wait_cnt <= '0;
      is_sw    <= 1'b0;
      rtype_op <= 4'b0010;
    end else begin
      // Every exit from a wait state (ack or expiry) clears the count for the next entry.
      wait_cnt <= (waiting && !mem_ack && !expire) ? wait_cnt + 1'b1 : '0;
      case (cur)
        FETCH:   if (mem_ack) cur <= DECODE;
                 else if (expire) cur <= FETCH;
        DECODE: begin
          is_sw    <= (opcode == OP_SW);
          rtype_op <= funct_op;
          case (opcode)
            OP_LW, OP_SW: cur <= MEMADR;
            OP_RTYPE:     cur <= funct_ok ? EXEC : FETCH;
            OP_BEQ:       cur <= BRANCH;
            OP_J:         cur <= JUMP;
            OP_ADDI:      cur <= ADDI_EX;
            default:      cur <= FETCH;
          endcase
        end
        MEMADR:  cur <= is_sw ? MEMWR : MEMRD;
        MEMRD:   if (mem_ack) cur <= MEMWB;
                 else if (expire) cur <= FETCH;
        MEMWR:   if (mem_ack || expire) cur <= FETCH;
        EXEC:    cur <= RWB;
        ADDI_EX: cur <= ADDI_WB;
        default: cur <= FETCH;  // single-step states and unreachable codes
      endcase
    end
  end

  assign state = cur;

  always_comb begin
    alu_op      = 4'b0010;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'd0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_en       = 1'b0;
    pc_source   = 2'd0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    illegal     = 1'b0;
    mem_timeout = expire;
    case (cur)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        // Gated by rst_n so an ack seen while held in reset cannot load IR/PC.
        ir_write  = mem_ack && rst_n;
        pc_en     = mem_ack && rst_n;
      end
      DECODE: begin
        alu_src_b = 2'd3;
        illegal   = !decode_ok;
      end
      MEMADR:  begin alu_src_a = 1'b1; alu_src_b = 2'd2; end
      MEMRD:   begin iord = 1'b1; mem_read = 1'b1; end
      MEMWB:   begin reg_write = 1'b1; mem_to_reg = 1'b1; end
      MEMWR:   begin iord = 1'b1; mem_write = 1'b1; end
      EXEC:    begin alu_src_a = 1'b1; alu_op = rtype_op; end
      RWB:     begin reg_write = 1'b1; reg_dst = 1'b1; end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 4'b0110;
        pc_source = 2'd1;
        pc_en     = zero;
      end
      JUMP:    begin pc_source = 2'd2; pc_en = 1'b1; end
      ADDI_EX: begin alu_src_a = 1'b1; alu_src_b = 2'd2; end
      ADDI_WB: reg_write = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_alu_control.sv
// Testbench for mc_alu_control: per-instruction expected traces built from the
// instruction-level rules, compared cycle by cycle against every DUT output.
module tb_mc_alu_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ack;
  logic [3:0] alu_op, state;
  logic       alu_src_a, iord, mem_read, mem_write, ir_write, pc_en;
  logic       reg_write, reg_dst, mem_to_reg, illegal, mem_timeout;
  logic [1:0] alu_src_b, pc_source;

  mc_alu_control #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ack(mem_ack), .alu_op(alu_op), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .pc_en(pc_en),
    .pc_source(pc_source), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .illegal(illegal), .mem_timeout(mem_timeout),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] op;
    logic       sa;
    logic [1:0] sb;
    logic       iord, mr, mw, irw, pce;
    logic [1:0] pcs;
    logic       rw, rd, m2r, ill, to;
  } obs_t;

  obs_t got;
  assign got = {state, alu_op, alu_src_a, alu_src_b, iord, mem_read, mem_write,
                ir_write, pc_en, pc_source, reg_write, reg_dst, mem_to_reg,
                illegal, mem_timeout};

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: expected trace and per-cycle stimulus queues.
  obs_t        exp_q[$];
  logic [13:0] stim_q[$];   // {opcode, funct, mem_ack, zero}
  logic [5:0]  cur_op, cur_fn;
  string       cur_tag;

  function automatic obs_t w(input int st);
    obs_t o = '0;
    o.st = 4'(st);
    o.op = 4'b0010;
    return o;
  endfunction

  task automatic push(input obs_t e, input logic ack, input logic z);
    exp_q.push_back(e);
    stim_q.push_back({cur_op, cur_fn, ack, z});
  endtask

  // n un-acked cycles before the ack; the 15th un-acked cycle times out instead.
  task automatic do_wait(input obs_t wt, input obs_t done, input int n, output bit to);
    obs_t e;
    to = 1'b0;
    for (int i = 0; i < n && i < 15; i++) begin
      e = wt;
      if (i == 14) begin e.to = 1'b1; to = 1'b1; end
      push(e, 1'b0, 1'($urandom));
    end
    if (!to) push(done, 1'b1, 1'($urandom));
  endtask

  function automatic bit fn_code(input logic [5:0] f, output logic [3:0] c);
    c = 4'b0010;
    case (f)
      6'h20: c = 4'b0010;  // add
      6'h22: c = 4'b0110;  // sub
      6'h24: c = 4'b0000;  // and
      6'h25: c = 4'b0001;  // or
      6'h2a: c = 4'b0111;  // slt
      6'h27: c = 4'b1100;  // nor
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int fw, input int mw);
    obs_t e, d;
    bit to;
    logic [3:0] c;
    bit fok;
    cur_op = op;
    cur_fn = fn;
    e = w(0); e.mr = 1; e.sb = 1;
    d = e; d.irw = 1; d.pce = 1;
    do_wait(e, d, fw, to);
    if (to) return;
    e = w(1); e.sb = 3;
    fok = fn_code(fn, c);
    case (op)
      6'b100011, 6'b101011: begin
        push(e, 1'($urandom), 1'($urandom));
        e = w(2); e.sa = 1; e.sb = 2; push(e, 1'($urandom), 1'($urandom));
        if (op == 6'b100011) begin
          e = w(3); e.iord = 1; e.mr = 1;
          do_wait(e, e, mw, to);
          if (!to) begin
            e = w(4); e.rw = 1; e.m2r = 1; push(e, 1'($urandom), 1'($urandom));
          end
        end else begin
          e = w(5); e.iord = 1; e.mw = 1;
          do_wait(e, e, mw, to);
        end
      end
      6'b000000: begin
        if (!fok) begin e.ill = 1; push(e, 1'($urandom), 1'($urandom)); return; end
        push(e, 1'($urandom), 1'($urandom));
        e = w(6); e.sa = 1; e.op = c; push(e, 1'($urandom), 1'($urandom));
        e = w(7); e.rw = 1; e.rd = 1; push(e, 1'($urandom), 1'($urandom));
      end
      6'b000100: begin
        push(e, 1'($urandom), 1'($urandom));
        e = w(8); e.sa = 1; e.op = 4'b0110; e.pcs = 1; e.pce = z;
        push(e, 1'($urandom), z);
      end
      6'b000010: begin
        push(e, 1'($urandom), 1'($urandom));
        e = w(9); e.pcs = 2; e.pce = 1; push(e, 1'($urandom), 1'($urandom));
      end
      6'b001000: begin
        push(e, 1'($urandom), 1'($urandom));
        e = w(10); e.sa = 1; e.sb = 2; push(e, 1'($urandom), 1'($urandom));
        e = w(11); e.rw = 1; push(e, 1'($urandom), 1'($urandom));
      end
      default: begin e.ill = 1; push(e, 1'($urandom), 1'($urandom)); end
    endcase
  endtask

  // Called at a negedge; drives each cycle's inputs, samples 1 ns later.
  task automatic run_q();
    logic [13:0] s;
    obs_t e;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      {opcode, funct, mem_ack, zero} = s;
      #1;
      chk(cur_tag, {9'd0, got}, {9'd0, e});
      @(negedge clk);
    end
  endtask

  logic [5:0] ops[6];
  logic [5:0] fns[6];
  obs_t       rst_word;

  initial begin
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27};
    rst_word = w(0); rst_word.mr = 1; rst_word.sb = 1;
    rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("reset", {9'd0, got}, {9'd0, rst_word});
    @(negedge clk);
    rst_n = 1'b1;

    cur_tag = "fetch_timeout";  instr(6'b000000, 6'h22, 1'b0, 15, 0); run_q();
    cur_tag = "rtype_sub";      instr(6'b000000, 6'h22, 1'b0, 0, 0);  run_q();
    cur_tag = "lw_wait3";       instr(6'b100011, 6'h00, 1'b0, 0, 3);  run_q();
    cur_tag = "beq_taken";      instr(6'b000100, 6'h00, 1'b1, 1, 0);  run_q();
    cur_tag = "beq_not_taken";  instr(6'b000100, 6'h00, 1'b0, 0, 0);  run_q();
    cur_tag = "illegal_op";     instr(6'b111111, 6'h20, 1'b0, 0, 0);  run_q();
    cur_tag = "illegal_funct";  instr(6'b000000, 6'h01, 1'b0, 0, 0);  run_q();
    cur_tag = "ack_at_expiry";  instr(6'b100011, 6'h00, 1'b0, 14, 14); run_q();
    cur_tag = "sw_timeout";     instr(6'b101011, 6'h00, 1'b0, 2, 20); run_q();
    cur_tag = "jump";           instr(6'b000010, 6'h00, 1'b0, 0, 0);  run_q();
    cur_tag = "addi";           instr(6'b001000, 6'h00, 1'b0, 0, 0);  run_q();

    // Reset asserted mid-MEMWR: enter MEMWR, then drop rst_n between edges.
    cur_tag = "sw_to_memwr";
    instr(6'b101011, 6'h00, 1'b0, 0, 0);
    void'(exp_q.pop_back());
    void'(stim_q.pop_back());
    run_q();
    mem_ack = 1'b0;
    #1 chk("in_memwr_state", {28'd0, state}, 32'd5);
    chk("in_memwr_write", {31'd0, mem_write}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_state", {28'd0, state}, 32'd0);
    chk("rst_mid_outputs", {9'd0, got}, {9'd0, rst_word});
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1 chk("rst_hold", {9'd0, got}, {9'd0, rst_word});
    end
    @(negedge clk);
    rst_n = 1'b1;

    cur_tag = "random";
    for (int k = 0; k < 60; k++) begin
      logic [5:0] op, fn;
      int fw, mw;
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
      fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
      fw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 16)) : int'($urandom_range(0, 3));
      mw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 16)) : int'($urandom_range(0, 3));
      instr(op, fn, 1'($urandom), fw, mw);
      run_q();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_alu_control.md
Name: mc_alu_control

Overview:
- Multicycle control FSM that drives the datapath ALU's 4-bit operation code and consumes its zero flag.
- Also sequences PC, IR, memory and register-file enables, one step per clock.
- Decodes the instruction register's opcode/funct and paces memory accesses with a req/ack handshake.
- Sits between the instruction register and the shared ALU/memory datapath.

Parameters:
- MEM_WAIT_MAX, 15, cycles to wait for mem_ack before asserting mem_timeout and returning to FETCH.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  IR[31:26], sampled in DECODE
- funct  input  6  IR[5:0], sampled in DECODE
- zero  input  1  ALU zero flag (aluresult == 0)
- mem_ack  input  1  memory completes the current read or write this cycle
- alu_op  output  4  ALU code: 0000 AND, 0001 OR, 0010 add, 0110 sub, 0111 slt, 1100 nor
- alu_src_a  output  1  0 = PC, 1 = register A
- alu_src_b  output  2  0 = B, 1 = constant 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  load IR
- pc_en  output  1  load PC
- pc_source  output  2  0 = ALU, 1 = ALUOut, 2 = jump target
- reg_write  output  1  register file write
- reg_dst  output  1  0 = rt, 1 = rd
- mem_to_reg  output  1  0 = ALUOut, 1 = MDR
- illegal  output  1  one-cycle pulse on an unsupported opcode or funct
- mem_timeout  output  1  one-cycle pulse when a memory wait expires
- state  output  4  current state encoding, for debug

Behaviour:
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11.
  - Encodings 12-15 are unreachable and go to FETCH next cycle.
- Reset:
  - rst_n low forces state=FETCH and clears the wait counter and the latched op class, immediately and asynchronously.
  - Outputs are decoded from state, so during and after reset: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=0010, and all other outputs are 0.
  - Reset mid-instruction abandons it; no partial writes occur after reset asserts.
- FETCH:
  - Holds with mem_read=1 until mem_ack=1.
  - In the mem_ack=1 cycle: ir_write=1, pc_en=1, pc_source=0 (PC+4), then go to DECODE.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=3, alu_op=0010 to precompute the branch target into ALUOut.
  - Next state by opcode: 100011 (lw) or 101011 (sw) -> MEMADR; 000000 (R-type) -> EXEC; 000100 (beq) -> BRANCH; 000010 (j) -> JUMP; 001000 (addi) -> ADDI_EX.
  - Any other opcode: illegal=1 for one cycle, then FETCH.
- MEMADR:
  - alu_src_a=1, alu_src_b=2, alu_op=0010.
  - Next state is MEMRD for lw, MEMWR for sw, using the op class latched in DECODE.
- MEMRD: iord=1, mem_read=1; holds until mem_ack, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, then FETCH.
- MEMWR: iord=1, mem_write=1; holds until mem_ack, then FETCH.
- EXEC:
  - alu_src_a=1, alu_src_b=0.
  - alu_op from funct, latched in DECODE: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111, 100111 -> 1100.
  - Unknown funct: illegal pulse in DECODE and go to FETCH; EXEC is never entered.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0, then FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=0, alu_op=0110, pc_source=1.
  - pc_en=zero, evaluated combinationally in the same cycle; then FETCH.
- JUMP: pc_source=2, pc_en=1, then FETCH.
- ADDI_EX / ADDI_WB: ADDI_EX drives alu_src_a=1, alu_src_b=2, alu_op=0010; ADDI_WB drives reg_write=1, reg_dst=0, mem_to_reg=0; then FETCH.
- Memory wait counter:
  - Counts cycles spent in FETCH, MEMRD or MEMWR with mem_ack=0; clears on state entry.
  - When the count reaches MEM_WAIT_MAX with no ack: mem_timeout=1 for one cycle, go to FETCH, no enables asserted.
  - mem_ack in the same cycle as expiry: the ack wins and the timeout is suppressed.
- Unused codes: alu_op defaults to 0010 in every state that does not specify it.
- Cycle counts with zero-wait memory: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.

Test Plan:
- Reset then hold mem_ack=0 -> state=0 and mem_read=1; after 15 cycles mem_timeout pulses once and state returns to 0.
- R-type sub (opcode 000000, funct 100010), ack every cycle -> states 0,1,6,7; alu_op=0110 in EXEC; reg_write=1 and reg_dst=1 only in RWB.
- lw with mem_ack delayed 3 cycles in MEMRD -> mem_read held for 3 cycles with iord=1; MEMWB asserts reg_write=1 and mem_to_reg=1 exactly once.
- beq with zero=1, then beq with zero=0 -> pc_en=1 with pc_source=1 in BRANCH for the first; pc_en=0 for the second.
- Opcode 111111, then R-type funct 000001 -> illegal pulses in DECODE each time; reg_write, mem_write and pc_en stay 0; next state is FETCH.
- rst_n dropped while in MEMWR with mem_ack=0 -> state=0 within the same cycle; mem_write deasserts immediately; no spurious reg_write.
